pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline registers (F/D, D/E, E/M, M/W).

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/md_busy_counter.sv | 51 +++++
 rtl/pipe_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline hazard/redirect controller.
// Contents: FSM state type, PC source selects, interrupt ExcCode, handler address,
// and width helpers for the multdiv busy counter.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_t;

  localparam logic [1:0]  PC_SEL_SEQ     = 2'd0;
  localparam logic [1:0]  PC_SEL_HANDLER = 2'd1;
  localparam logic [1:0]  PC_SEL_EPC     = 2'd2;

  localparam logic [4:0]  EXC_INT        = 5'd0;
  localparam logic [31:0] HANDLER_ADDR   = 32'h0000_4180;

  // Larger of two cycle counts.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Multdiv busy tracker: loads the mult or div latency on an issue, counts down to
// zero, and clears immediately on abort (exception/interrupt redirect).
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   start          mult/div issues in E (ignored while busy)
//   is_div         qualifies start: 1=div, 0=mult
//   abort          cancel any operation in flight
//   busy           registered, high while the counter is non-zero
module md_busy_counter #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  input  logic abort,
  output logic busy
);
  import pipe_ctrl_pkg::*;

  localparam int unsigned MAX_CYC = max_u(MULT_CYC, DIV_CYC);
  localparam int unsigned CW      = cnt_width(MAX_CYC);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;

  // Next count: abort beats everything, a running count ignores new starts.
  always_comb begin
    cnt_d = cnt;
    if (abort) begin
      cnt_d = '0;
    end else if (cnt != '0) begin
      cnt_d = cnt - CW'(1);
    end else if (start) begin
      cnt_d = is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end
  end

  // busy is registered alongside the count so it equals (cnt != 0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      busy <= (cnt_d != '0);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the F/D, D/E, E/M and M/W pipeline registers.
// Merges load-use and HI/LO hazards with interrupt, exception and eret redirects.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   load_use_D, md_use_D       hazard requests from decode
//   md_start_E, md_is_div_E    multdiv issue in execute
//   exp_M, int_req, eret_M     redirect sources (exp_M = ExcCode+1, 0 = none)
//   stall_F, stall_D           hold PC / F/D
//   clr_D, clr_E, clr_M, clr_W clear F/D, D/E, E/M, M/W
//   pc_sel                     0 = sequential, 1 = handler, 2 = EPC
//   exc_take                   CP0 latches EPC/cause this cycle
//   exccode                    registered ExcCode of the last taken event
//   md_busy                    registered multdiv busy
// Build option PIPE_HAZARD_CTRL_PERF_EN adds saturating stall_cnt / flush_cnt.
// Control outputs are combinational from state and inputs and are forced low in reset.
module pipe_hazard_ctrl #(
  parameter int unsigned MULT_CYC  = 5,
  parameter int unsigned DIV_CYC   = 10,
  parameter int unsigned FLUSH_CYC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_use_D,
  input  logic       md_start_E,
  input  logic       md_is_div_E,
  input  logic       md_use_D,
  input  logic [4:0] exp_M,
  input  logic       int_req,
  input  logic       eret_M,
  output logic       stall_F,
  output logic       stall_D,
  output logic       clr_D,
  output logic       clr_E,
  output logic       clr_M,
  output logic       clr_W,
  output logic [1:0] pc_sel,
  output logic       exc_take,
  output logic [4:0] exccode,
  output logic       md_busy
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  import pipe_ctrl_pkg::*;

  localparam int unsigned FW = 2;

  ctrl_state_t   state;
  ctrl_state_t   state_d;
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_d;
  logic [4:0]    exccode_d;
  logic          md_start;
  logic          md_abort;

  // Event arbitration and output decode; RUN is the only state that looks at events.
  always_comb begin
    stall_F   = 1'b0;
    stall_D   = 1'b0;
    clr_D     = 1'b0;
    clr_E     = 1'b0;
    clr_M     = 1'b0;
    clr_W     = 1'b0;
    pc_sel    = PC_SEL_SEQ;
    exc_take  = 1'b0;
    state_d   = state;
    fcnt_d    = fcnt;
    exccode_d = exccode;
    md_start  = 1'b0;
    md_abort  = 1'b0;
    if (!reset) begin
      unique case (state)
        RUN: begin
          md_start = md_start_E;
          if (int_req || (exp_M != 5'd0)) begin
            clr_D     = 1'b1;
            clr_E     = 1'b1;
            clr_M     = 1'b1;
            clr_W     = 1'b1;
            pc_sel    = PC_SEL_HANDLER;
            exc_take  = 1'b1;
            exccode_d = int_req ? EXC_INT : 5'(exp_M - 5'd1);
            md_abort  = 1'b1;
            state_d   = FLUSH;
            fcnt_d    = FW'(FLUSH_CYC);
          end else if (eret_M) begin
            // eret itself completes, so M/W keeps its writeback.
            clr_D   = 1'b1;
            clr_E   = 1'b1;
            clr_M   = 1'b1;
            pc_sel  = PC_SEL_EPC;
            state_d = FLUSH;
            fcnt_d  = FW'(FLUSH_CYC);
          end else if ((md_use_D && (md_busy || md_start_E)) || load_use_D) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            clr_E   = 1'b1;
          end
        end
        FLUSH: begin
          clr_D = 1'b1;
          clr_E = 1'b1;
          if (fcnt <= FW'(1)) begin
            state_d = RUN;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt - FW'(1);
          end
        end
      endcase
    end
  end

  // FSM, flush counter and ExcCode register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      fcnt    <= '0;
      exccode <= EXC_INT;
    end else begin
      state   <= state_d;
      fcnt    <= fcnt_d;
      exccode <= exccode_d;
    end
  end

  md_busy_counter #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .is_div (md_is_div_E),
    .abort  (md_abort),
    .busy   (md_busy)
  );

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic flush_evt;

  // A redirect cycle or any FLUSH cycle counts as flush time.
  assign flush_evt = (state == FLUSH) || exc_take || (pc_sel == PC_SEL_EPC);

  // Saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_F && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush_evt && (flush_cnt != 32'hFFFF_FFFF)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (default parameters: MULT 5, DIV 10, FLUSH 1).
// The driver applies one input vector per cycle and queues the expected output word;
// a monitor pops and compares on the falling edge (or on demand for async reset).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_use_D = 1'b0;
  logic       md_start_E = 1'b0;
  logic       md_is_div_E = 1'b0;
  logic       md_use_D = 1'b0;
  logic [4:0] exp_M = 5'd0;
  logic       int_req = 1'b0;
  logic       eret_M = 1'b0;
  logic       stall_F, stall_D, clr_D, clr_E, clr_M, clr_W;
  logic [1:0] pc_sel;
  logic       exc_take;
  logic [4:0] exccode;
  logic       md_busy;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .load_use_D  (load_use_D),
    .md_start_E  (md_start_E),
    .md_is_div_E (md_is_div_E),
    .md_use_D    (md_use_D),
    .exp_M       (exp_M),
    .int_req     (int_req),
    .eret_M      (eret_M),
    .stall_F     (stall_F),
    .stall_D     (stall_D),
    .clr_D       (clr_D),
    .clr_E       (clr_E),
    .clr_M       (clr_M),
    .clr_W       (clr_W),
    .pc_sel      (pc_sel),
    .exc_take    (exc_take),
    .exccode     (exccode),
    .md_busy     (md_busy)
  );

  // Output word: {stall_F,stall_D,clr_D,clr_E,clr_M,clr_W,pc_sel,exc_take,exccode,md_busy}
  logic [14:0] act;
  assign act = {stall_F, stall_D, clr_D, clr_E, clr_M, clr_W, pc_sel, exc_take, exccode, md_busy};

  logic [14:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          failures = 0;
  event        smp;

  function automatic logic [14:0] ev(input logic sf, input logic sd, input logic cd,
                                     input logic ce, input logic cm, input logic cw,
                                     input logic [1:0] pc, input logic et,
                                     input logic [4:0] ec, input logic b);
    return {sf, sd, cd, ce, cm, cw, pc, et, ec, b};
  endfunction

  function automatic logic [14:0] idle(input logic [4:0] ec, input logic b);
    return ev(0, 0, 0, 0, 0, 0, 2'd0, 0, ec, b);
  endfunction
  function automatic logic [14:0] stall(input logic [4:0] ec, input logic b);
    return ev(1, 1, 0, 1, 0, 0, 2'd0, 0, ec, b);
  endfunction
  function automatic logic [14:0] take(input logic [4:0] ec, input logic b);
    return ev(0, 0, 1, 1, 1, 1, 2'd1, 1, ec, b);
  endfunction
  function automatic logic [14:0] eret(input logic [4:0] ec, input logic b);
    return ev(0, 0, 1, 1, 1, 0, 2'd2, 0, ec, b);
  endfunction
  function automatic logic [14:0] flush(input logic [4:0] ec, input logic b);
    return ev(0, 0, 1, 1, 0, 0, 2'd0, 0, ec, b);
  endfunction

  // Monitor: compare every queued expectation against the live outputs.
  initial begin
    forever begin
      @(negedge clk or smp);
      while (exp_q.size() != 0) begin
        logic [14:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL %s: got %b expected %b", n, act, e);
        end
      end
    end
  end

  task automatic set_in(input logic lu, input logic ms, input logic md, input logic mu,
                        input logic [4:0] em, input logic ir, input logic er);
    load_use_D  = lu;
    md_start_E  = ms;
    md_is_div_E = md;
    md_use_D    = mu;
    exp_M       = em;
    int_req     = ir;
    eret_M      = er;
  endtask

  task automatic cyc(input string n, input logic lu, input logic ms, input logic md,
                     input logic mu, input logic [4:0] em, input logic ir, input logic er,
                     input logic [14:0] e);
    @(posedge clk);
    #1;
    set_in(lu, ms, md, mu, em, ir, er);
    name_q.push_back(n);
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Outputs held low in reset regardless of inputs.
    cyc("rst_lu",  1, 0, 0, 0, 5'd0, 0, 0, 15'd0);
    cyc("rst_exc", 0, 0, 0, 0, 5'd5, 1, 1, 15'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    set_in(0, 0, 0, 0, 5'd0, 0, 0);

    cyc("idle",   0, 0, 0, 0, 5'd0, 0, 0, idle(0, 0));
    cyc("lu",     1, 0, 0, 0, 5'd0, 0, 0, stall(0, 0));
    cyc("lu_off", 0, 0, 0, 0, 5'd0, 0, 0, idle(0, 0));

    // div then mfhi: stall cycles 0..10, busy 1..10, released at 11.
    cyc("div_issue", 0, 1, 1, 1, 5'd0, 0, 0, stall(0, 0));
    for (int i = 1; i <= 10; i++) cyc("div_wait", 0, 0, 0, 1, 5'd0, 0, 0, stall(0, 1));
    cyc("div_done", 0, 0, 0, 1, 5'd0, 0, 0, idle(0, 0));

    // mult without a HI/LO consumer: busy 1..5, no stall.
    cyc("mul_issue", 0, 1, 0, 0, 5'd0, 0, 0, idle(0, 0));
    for (int i = 1; i <= 5; i++) cyc("mul_busy", 0, 0, 0, 0, 5'd0, 0, 0, idle(0, 1));
    cyc("mul_done", 0, 0, 0, 0, 5'd0, 0, 0, idle(0, 0));

    // Exception AdEL; FLUSH ignores events presented to it.
    cyc("exc_take",  0, 0, 0, 0, 5'd5, 0, 0, take(0, 0));
    cyc("exc_flush", 1, 0, 0, 1, 5'd3, 1, 1, flush(4, 0));
    cyc("exc_run",   0, 0, 0, 0, 5'd0, 0, 0, idle(4, 0));

    // Interrupt beats exception and eret; then exception beats eret.
    cyc("int_win",       0, 0, 0, 0, 5'd11, 1, 1, take(4, 0));
    cyc("int_flush",     0, 0, 0, 0, 5'd0,  0, 0, flush(0, 0));
    cyc("int_run",       0, 0, 0, 0, 5'd0,  0, 0, idle(0, 0));
    cyc("exc_win",       0, 0, 0, 0, 5'd11, 0, 1, take(0, 0));
    cyc("exc_win_flush", 0, 0, 0, 0, 5'd0,  0, 0, flush(10, 0));
    cyc("exc_win_run",   0, 0, 0, 0, 5'd0,  0, 0, idle(10, 0));

    // eret outranks a load-use stall and keeps M/W.
    cyc("eret",       1, 0, 0, 0, 5'd0, 0, 1, eret(10, 0));
    cyc("eret_flush", 0, 0, 0, 0, 5'd0, 0, 0, flush(10, 0));
    cyc("eret_run",   0, 0, 0, 0, 5'd0, 0, 0, idle(10, 0));

    // Exception 3 cycles after a div issue aborts the divider.
    cyc("ab_issue",   0, 1, 1, 0, 5'd0, 0, 0, idle(10, 0));
    cyc("ab_b1",      0, 0, 0, 0, 5'd0, 0, 0, idle(10, 1));
    cyc("ab_b2",      0, 0, 0, 0, 5'd0, 0, 0, idle(10, 1));
    cyc("ab_exc",     0, 0, 0, 0, 5'd1, 0, 0, take(10, 1));
    cyc("ab_flush",   0, 0, 0, 1, 5'd0, 0, 0, flush(0, 0));
    cyc("ab_nostall", 0, 0, 0, 1, 5'd0, 0, 0, idle(0, 0));

    // Leave a non-zero exccode, then reset mid-FLUSH with a div in flight.
    cyc("pre_exc",   0, 0, 0, 0, 5'd8, 0, 0, take(0, 0));
    cyc("pre_flush", 0, 0, 0, 0, 5'd0, 0, 0, flush(7, 0));
    cyc("pre_run",   0, 0, 0, 0, 5'd0, 0, 0, idle(7, 0));
    cyc("rs_issue",  0, 1, 1, 0, 5'd0, 0, 0, idle(7, 0));
    cyc("rs_b1",     0, 0, 0, 0, 5'd0, 0, 0, idle(7, 1));
    cyc("rs_eret",   0, 0, 0, 0, 5'd0, 0, 1, eret(7, 1));
    cyc("rs_flush",  0, 0, 0, 0, 5'd0, 0, 0, flush(7, 1));
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    name_q.push_back("rst_async");
    exp_q.push_back(15'd0);
    ->smp;
    cyc("rst_hold", 1, 0, 0, 0, 5'd0, 0, 0, 15'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    set_in(0, 0, 0, 0, 5'd0, 0, 0);
    cyc("post_idle", 0, 0, 0, 1, 5'd0, 0, 0, idle(0, 0));
    cyc("post_lu",   1, 0, 0, 0, 5'd0, 0, 0, stall(0, 0));

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
